// File: rtl/bit_serializer_pkg.sv
// Shared types and default sizing for the bit serializer.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DIV   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// Control/data bundle between a frame producer and the bit serializer.
interface bit_serializer_if
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             bit_out;
  logic             bit_en;
  logic             mostrar_dato;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, data_in,
    input  bit_out, bit_en, mostrar_dato, busy, done
  );

  modport slave (
    input  start, abort, data_in,
    output bit_out, bit_en, mostrar_dato, busy, done
  );

endinterface

// File: rtl/bit_serializer_tick.sv
// Per-bit strobe generator: counts DIV cycles while run is high.
module bit_tick_gen
  import serializer_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count 0..DIV-1 while running; park at zero otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with DIV-cycle bit period and abort.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIV   = DEFAULT_DIV
) (
  input  logic          clk,
  input  logic          reset,
  bit_serializer_if.slave bus
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bitcnt_q, bitcnt_d;
  logic             bit_out_q, busy_q, done_q, mostrar_q;
  logic             run;
  logic             tick;

  assign run = (state_q == ST_SHIFT);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  // Next-state: abort beats the final-bit transition into DONE.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d  = bus.data_in;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          shreg_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_IDLE;
        end else if (tick) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q + BCW'(1);
          if (bitcnt_q == BCW'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs track the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      bit_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mostrar_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      bit_out_q <= (state_d == ST_SHIFT) ? shreg_d[WIDTH-1] : 1'b0;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      mostrar_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.bit_out      = bit_out_q;
  assign bus.bit_en       = tick;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mostrar_dato = mostrar_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench: DIV=4 and DIV=1 serializers, checked cycle by cycle.
module tb_bit_serializer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bit_serializer_if #(.WIDTH(8)) if4 ();
  bit_serializer_if #(.WIDTH(8)) if1 ();

  bit_serializer #(.WIDTH(8), .DIV(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  bit_serializer #(.WIDTH(8), .DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    if4.start = 1'b0; if4.abort = 1'b0; if4.data_in = 8'h00;
    if1.start = 1'b0; if1.abort = 1'b0; if1.data_in = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({if4.bit_out, if4.bit_en, if4.mostrar_dato, if4.busy, if4.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_div4 got %b exp 00000",
               {if4.bit_out, if4.bit_en, if4.mostrar_dato, if4.busy, if4.done});
    end
    n_tests++;
    if ({if1.bit_out, if1.bit_en, if1.mostrar_dato, if1.busy, if1.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_div1 got %b exp 00000",
               {if1.bit_out, if1.bit_en, if1.mostrar_dato, if1.busy, if1.done});
    end
    reset = 1'b0;
  endtask

  // Full 8'hA5 frame at DIV=4: bit_en every 4th cycle, done at 33.
  task automatic test_frame_div4(input string tag);
    logic [7:0] d;
    logic [3:0] exp_v, obs_v;
    logic       en, bz, dn, eb;
    d = 8'hA5;
    @(negedge clk);
    if4.start = 1'b1; if4.data_in = d;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c == 1) if4.start = 1'b0;
      en = (c % 4 == 0) && (c <= 32);
      bz = (c <= 33);
      dn = (c == 33);
      exp_v = {en, bz, bz, dn};
      obs_v = {if4.bit_en, if4.busy, if4.mostrar_dato, if4.done};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s_ctl cyc %0d got %b exp %b", tag, c, obs_v, exp_v);
      end
      if (en || !bz) begin
        eb = en ? d[8 - c / 4] : 1'b0;
        n_tests++;
        if (if4.bit_out !== eb) begin
          n_fail++;
          $display("FAIL %s_bit cyc %0d got %b exp %b", tag, c, if4.bit_out, eb);
        end
      end
    end
  endtask

  // Start pulses in SHIFT and in DONE must be ignored.
  task automatic test_mid_start();
    logic [7:0] d;
    logic [3:0] exp_v, obs_v;
    logic       en, bz, dn, eb;
    d = 8'hA5;
    @(negedge clk);
    if4.start = 1'b1; if4.data_in = d;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (c == 1)  if4.start = 1'b0;
      if (c == 10) begin if4.start = 1'b1; if4.data_in = 8'hFF; end
      if (c == 11) if4.start = 1'b0;
      if (c == 33) if4.start = 1'b1;
      if (c == 34) if4.start = 1'b0;
      en = (c % 4 == 0) && (c <= 32);
      bz = (c <= 33);
      dn = (c == 33);
      exp_v = {en, bz, bz, dn};
      obs_v = {if4.bit_en, if4.busy, if4.mostrar_dato, if4.done};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL mid_start_ctl cyc %0d got %b exp %b", c, obs_v, exp_v);
      end
      if (en || !bz) begin
        eb = en ? d[8 - c / 4] : 1'b0;
        n_tests++;
        if (if4.bit_out !== eb) begin
          n_fail++;
          $display("FAIL mid_start_bit cyc %0d got %b exp %b", c, if4.bit_out, eb);
        end
      end
    end
  endtask

  // Abort right after the 3rd bit strobe: idle next edge, no done.
  task automatic test_abort();
    logic [4:0] exp_v, obs_v;
    logic       en, bz;
    @(negedge clk);
    if4.start = 1'b1; if4.data_in = 8'hA5;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1)  if4.start = 1'b0;
      if (c == 13) if4.abort = 1'b1;
      if (c == 14) if4.abort = 1'b0;
      en = (c % 4 == 0) && (c <= 12);
      bz = (c <= 13);
      exp_v = {en, bz, bz, 1'b0, (c >= 14) ? 1'b0 : if4.bit_out};
      obs_v = {if4.bit_en, if4.busy, if4.mostrar_dato, if4.done, if4.bit_out};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL abort cyc %0d got %b exp %b", c, obs_v, exp_v);
      end
    end
  endtask

  // Abort on the final bit strobe beats DONE; abort in IDLE is ignored.
  task automatic test_abort_priority();
    logic [3:0] exp_v, obs_v;
    logic       en, bz;
    @(negedge clk);
    if4.start = 1'b1; if4.abort = 1'b1; if4.data_in = 8'hA5;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1)  begin if4.start = 1'b0; if4.abort = 1'b0; end
      if (c == 32) if4.abort = 1'b1;
      if (c == 33) if4.abort = 1'b0;
      en = (c % 4 == 0) && (c <= 32);
      bz = (c <= 32);
      exp_v = {en, bz, bz, 1'b0};
      obs_v = {if4.bit_en, if4.busy, if4.mostrar_dato, if4.done};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL abort_prio cyc %0d got %b exp %b", c, obs_v, exp_v);
      end
    end
  endtask

  // Second frame started in the single idle cycle after done.
  task automatic test_back_to_back();
    logic [7:0] d1, d2, d;
    logic [3:0] exp_v, obs_v;
    logic       en, bz, dn, eb;
    int         k;
    d1 = 8'hA5;
    d2 = 8'h3C;
    @(negedge clk);
    if4.start = 1'b1; if4.data_in = d1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1)  if4.start = 1'b0;
      if (c == 34) begin if4.start = 1'b1; if4.data_in = d2; end
      if (c == 35) if4.start = 1'b0;
      if (c <= 33) begin k = c; d = d1; end
      else begin k = c - 34; d = d2; end
      en = (k >= 1) && (k <= 32) && (k % 4 == 0);
      bz = (k >= 1) && (k <= 33);
      dn = (k == 33);
      exp_v = {en, bz, bz, dn};
      obs_v = {if4.bit_en, if4.busy, if4.mostrar_dato, if4.done};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_ctl cyc %0d got %b exp %b", c, obs_v, exp_v);
      end
      if (en || !bz) begin
        eb = en ? d[8 - k / 4] : 1'b0;
        n_tests++;
        if (if4.bit_out !== eb) begin
          n_fail++;
          $display("FAIL b2b_bit cyc %0d got %b exp %b", c, if4.bit_out, eb);
        end
      end
    end
  endtask

  // DIV=1: eight consecutive strobes carrying 8'h81.
  task automatic test_div1();
    logic [7:0] d;
    logic [3:0] exp_v, obs_v;
    logic       en, bz, dn, eb;
    d = 8'h81;
    @(negedge clk);
    if1.start = 1'b1; if1.data_in = d;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) if1.start = 1'b0;
      en = (c <= 8);
      bz = (c <= 9);
      dn = (c == 9);
      exp_v = {en, bz, bz, dn};
      obs_v = {if1.bit_en, if1.busy, if1.mostrar_dato, if1.done};
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL div1_ctl cyc %0d got %b exp %b", c, obs_v, exp_v);
      end
      if (en || !bz) begin
        eb = en ? d[8 - c] : 1'b0;
        n_tests++;
        if (if1.bit_out !== eb) begin
          n_fail++;
          $display("FAIL div1_bit cyc %0d got %b exp %b", c, if1.bit_out, eb);
        end
      end
    end
  endtask

  // Async reset mid-SHIFT clears outputs before the next edge.
  task automatic test_reset_mid();
    @(negedge clk);
    if4.start = 1'b1; if4.data_in = 8'hA5;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) if4.start = 1'b0;
    end
    n_tests++;
    if (if4.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre busy got %b exp 1", if4.busy);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({if4.bit_out, if4.bit_en, if4.mostrar_dato, if4.busy, if4.done} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async got %b exp 00000",
               {if4.bit_out, if4.bit_en, if4.mostrar_dato, if4.busy, if4.done});
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_frame_div4("after_rst");
  endtask

  initial begin
    clk     = 1'b0;
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_frame_div4("frame_a5");
    test_mid_start();
    test_abort();
    test_abort_priority();
    test_back_to_back();
    test_div1();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
